// File: rtl/mux4_1_logic_if.sv
`default_nettype none
// ============================================================================
// mux4_1_logic_if : lane/select/enable bundle and results of mux4_1_logic
// Revision: 1.0
// ============================================================================
interface mux4_1_logic_if #(
    parameter int WIDTH = 1
);
    logic [4*WIDTH-1:0] d;
    logic [1:0]         s;
    logic               en;
    logic [WIDTH-1:0]   y;
    logic [3:0]         sel_oh;
    logic [WIDTH-1:0]   y_q;
    logic [1:0]         s_q;
    logic               y_vld;

    modport master (
        output d, s, en,
        input  y, sel_oh, y_q, s_q, y_vld
    );

    modport slave (
        input  d, s, en,
        output y, sel_oh, y_q, s_q, y_vld
    );
endinterface
`default_nettype wire

// File: rtl/mux4_1_logic.sv
`default_nettype none
// ============================================================================
// mux4_1_logic : 4-to-1 lane mux with one-hot decode and registered copy
// Revision: 1.0
// ============================================================================
module mux4_1_logic #(
    parameter int WIDTH = 1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mux4_1_logic_if.slave  bus
);
    logic [WIDTH-1:0] lane_w [4];
    logic [WIDTH-1:0] y_w;
    logic [3:0]       oh_w;
    logic [WIDTH-1:0] y_cap_d, y_cap_q;
    logic [1:0]       s_cap_d, s_cap_q;
    logic             vld_d, vld_q;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane_w[k] = bus.d[k*WIDTH +: WIDTH];
    end

    // Non-2-state selects fall into default so X on d never reaches y
    always_comb begin
        y_w  = '0;
        oh_w = 4'b0000;
        case (bus.s)
            2'd0: begin y_w = lane_w[0]; oh_w = 4'b0001; end
            2'd1: begin y_w = lane_w[1]; oh_w = 4'b0010; end
            2'd2: begin y_w = lane_w[2]; oh_w = 4'b0100; end
            2'd3: begin y_w = lane_w[3]; oh_w = 4'b1000; end
            default: begin y_w = '0; oh_w = 4'b0000; end
        endcase
    end

    always_comb begin
        y_cap_d = y_cap_q;
        s_cap_d = s_cap_q;
        vld_d   = 1'b0;
        if (bus.en) begin
            y_cap_d = y_w;
            s_cap_d = bus.s;
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_cap_q <= '0;
            s_cap_q <= 2'd0;
            vld_q   <= 1'b0;
        end else begin
            y_cap_q <= y_cap_d;
            s_cap_q <= s_cap_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.y      = y_w;
    assign bus.sel_oh = oh_w;
    assign bus.y_q    = y_cap_q;
    assign bus.s_q    = s_cap_q;
    assign bus.y_vld  = vld_q;
endmodule
`default_nettype wire

// File: tb/tb_mux4_1_logic.sv
`default_nettype none
// ============================================================================
// tb_mux4_1_logic : directed bench for mux4_1_logic at WIDTH=1 and WIDTH=8
// Revision: 1.0
// ============================================================================
module tb_mux4_1_logic;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux4_1_logic_if #(.WIDTH(1)) if1 ();
    mux4_1_logic_if #(.WIDTH(8)) if8 ();

    mux4_1_logic #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux4_1_logic #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] dd;
        logic [1:0] ss;
        logic [3:0] oh;
        logic [1:0] sx;
        logic [7:0] exp8 [4];
        n_cmp = 0;
        n_err = 0;
        exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;

        rst_n  = 1'b0;
        if1.d  = '0; if1.s = 2'd0; if1.en = 1'b0;
        if8.d  = '0; if8.s = 2'd0; if8.en = 1'b0;
        @(posedge clk); #1;
        chk("rst_y_q1",  32'(if1.y_q),   32'd0);
        chk("rst_s_q1",  32'(if1.s_q),   32'd0);
        chk("rst_vld1",  32'(if1.y_vld), 32'd0);
        chk("rst_y_q8",  32'(if8.y_q),   32'd0);
        chk("rst_vld8",  32'(if8.y_vld), 32'd0);

        // Exhaustive WIDTH=1 sweep over {d,s}
        for (int i = 0; i < 64; i++) begin
            {if1.d, if1.s} = 6'(i);
            #5;
            dd = 4'(i >> 2);
            ss = 2'(i);
            oh = 4'b0001 << ss;
            chk($sformatf("sweep_y_%0d", i),  32'(if1.y),      32'(dd[ss]));
            chk($sformatf("sweep_oh_%0d", i), 32'(if1.sel_oh), 32'(oh));
        end

        // Combinational path live under reset; reset beats en
        @(posedge clk); #1;
        rst_n = 1'b0; if1.d = 4'b0100; if1.s = 2'd2; if1.en = 1'b1;
        #1;
        chk("rstcomb_y",  32'(if1.y),      32'd1);
        chk("rstcomb_oh", 32'(if1.sel_oh), 32'h4);
        @(posedge clk); #1;
        chk("rstcomb_y_q", 32'(if1.y_q),   32'd0);
        chk("rstcomb_s_q", 32'(if1.s_q),   32'd0);
        chk("rstcomb_vld", 32'(if1.y_vld), 32'd0);

        // Registered capture then hold
        rst_n = 1'b1; if1.en = 1'b1; if1.d = 4'b1000; if1.s = 2'd3;
        @(posedge clk); #1;
        chk("cap_y_q", 32'(if1.y_q),   32'd1);
        chk("cap_s_q", 32'(if1.s_q),   32'd3);
        chk("cap_vld", 32'(if1.y_vld), 32'd1);
        if1.en = 1'b0; if1.d = 4'b0000;
        @(posedge clk); #1;
        chk("hold_y",   32'(if1.y),     32'd0);
        chk("hold_y_q", 32'(if1.y_q),   32'd1);
        chk("hold_s_q", 32'(if1.s_q),   32'd3);
        chk("hold_vld", 32'(if1.y_vld), 32'd0);

        // Back-to-back enables
        if1.en = 1'b1; if1.d = 4'b0110; if1.s = 2'd1;
        @(posedge clk); #1;
        chk("b2b0_y_q", 32'(if1.y_q),   32'd1);
        chk("b2b0_s_q", 32'(if1.s_q),   32'd1);
        chk("b2b0_vld", 32'(if1.y_vld), 32'd1);
        if1.s = 2'd0;
        @(posedge clk); #1;
        chk("b2b1_y_q", 32'(if1.y_q),   32'd0);
        chk("b2b1_s_q", 32'(if1.s_q),   32'd0);
        chk("b2b1_vld", 32'(if1.y_vld), 32'd1);

        // Reset priority over en with selected lane = 1
        rst_n = 1'b0; if1.en = 1'b1; if1.d = 4'b1111; if1.s = 2'd2;
        @(posedge clk); #1;
        chk("prio_y_q", 32'(if1.y_q),   32'd0);
        chk("prio_s_q", 32'(if1.s_q),   32'd0);
        chk("prio_vld", 32'(if1.y_vld), 32'd0);

        // Release with en high: capture on the first edge out of reset
        rst_n = 1'b1; if1.d = 4'b0010; if1.s = 2'd1;
        @(posedge clk); #1;
        chk("rel_y_q", 32'(if1.y_q),   32'd1);
        chk("rel_s_q", 32'(if1.s_q),   32'd1);
        chk("rel_vld", 32'(if1.y_vld), 32'd1);
        if1.en = 1'b0;

        // WIDTH=8 lanes, combinational and one cycle later registered
        if8.d  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        if8.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if8.s = 2'(k);
            #1;
            chk($sformatf("w8_y_%0d", k), 32'(if8.y), 32'(exp8[k]));
            @(posedge clk); #1;
            chk($sformatf("w8_y_q_%0d", k), 32'(if8.y_q),   32'(exp8[k]));
            chk($sformatf("w8_s_q_%0d", k), 32'(if8.s_q),   32'(k));
            chk($sformatf("w8_vld_%0d", k), 32'(if8.y_vld), 32'd1);
        end
        if8.en = 1'b0; if8.s = 2'd0;
        @(posedge clk); #1;
        chk("w8_hold_y_q", 32'(if8.y_q),   32'hDD);
        chk("w8_hold_vld", 32'(if8.y_vld), 32'd0);
        chk("w8_hold_y",   32'(if8.y),     32'hAA);

        // Unknown select; a 2-state simulator may resolve the X bit
        sx = 2'bx1;
        if1.d = 4'b1111;
        if1.s = sx;
        #1;
        if ($isunknown(if1.s)) begin
            oh = 4'b0000;
            dd = 4'b0000;
        end else begin
            oh = 4'b0001 << if1.s;
            dd = {3'b000, if1.d[if1.s]};
        end
        chk("unk_y",  32'(if1.y),      32'(dd));
        chk("unk_oh", 32'(if1.sel_oh), 32'(oh));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux4_1_logic.md
Name:
mux4_1_logic

Overview:
- 4-to-1 multiplexer selecting one of four data lanes by a 2-bit select.
- Provides a purely combinational output, a one-hot select decode, and a one-cycle registered copy of the result with a valid flag.
- Used as a leaf datapath primitive wherever a lane pick is needed, either inline (combinational path) or pipelined (registered path).

Parameters:
- WIDTH, 1, bit width of each data lane and of both data outputs; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; used by the registered path only.
- rst_n  input  1  synchronous active-low reset; used by the registered path only.
- d  input  4*WIDTH  packed lanes; lane k occupies bits d[k*WIDTH +: WIDTH]. With WIDTH=1, lane k is d[k].
- s  input  2  lane select, 0..3.
- en  input  1  capture enable for the registered path.
- y  output  WIDTH  combinational selected lane.
- sel_oh  output  4  combinational one-hot decode of s; bit k is set when s==k.
- y_q  output  WIDTH  registered selected lane.
- s_q  output  2  select value captured together with y_q.
- y_vld  output  1  high for exactly the cycle after an enabled capture.

Behaviour:
- Combinational output: y = lane s of d; y equals d[s] for WIDTH=1.
  - Zero latency; any change on d or s is reflected on y within the same delta.
  - y does not depend on clk, rst_n or en, and is valid even while rst_n is low.
- One-hot decode: sel_oh = 4'b0001 << s.
  - Exactly one bit is high for any 2-state s.
  - Combinational and independent of reset.
- Unknown select: if s contains X or Z, the default branch drives y = 0 and sel_oh = 4'b0000. This is deterministic and never propagates X from d.
- Registered path (all updates on the rising edge of clk, reset synchronous):
  - rst_n==0 at the edge: y_q = 0, s_q = 0, y_vld = 0. This holds regardless of en, d and s.
  - rst_n==1 and en==1: y_q <= y, s_q <= s, y_vld <= 1.
  - rst_n==1 and en==0: y_q and s_q hold their values, y_vld <= 0.
  - Latency from d/s to y_q is one cycle.
  - Back-to-back en keeps y_vld high continuously, and y_q tracks lane s each cycle.
  - If rst_n is asserted in the same cycle as en=1, reset wins.
  - If rst_n is released with en=1 at that edge, the capture occurs on the first edge where rst_n==1.
- Power-up: registered outputs are undefined until the first clock edge with rst_n==0. Combinational outputs are valid immediately.
- Width rules: no arithmetic; every output bit maps directly to the corresponding bit of the selected lane. Upper lanes are never truncated or sign-extended.

Test Plan:
- WIDTH=1, exhaustive sweep: drive {d,s} = i for i = 0..63, wait 5 ns each.
  - Required: y === d[s] for every combination, e.g. d=4'b1010, s=2'd1 -> y=1; d=4'b1010, s=2'd2 -> y=0.
  - sel_oh matches 1<<s for every combination.
- Combinational independence from reset: hold rst_n=0, d=4'b0100, s=2'd2.
  - Required: y=1 and sel_oh=4'b0100 immediately.
  - y_q=0 and y_vld=0 after the clock edge.
- Registered capture: rst_n=1, en=1, d=4'b1000, s=3 at edge N.
  - Required after edge N: y_q=1, s_q=3, y_vld=1.
  - With en=0 at edge N+1: y_q stays 1, y_vld=0, even though d changes to 0.
- Reset priority: rst_n=0 and en=1 at the same edge with a selected lane value of 1.
  - Required: y_q=0, s_q=0, y_vld=0.
- WIDTH=8: d={8'hDD,8'hCC,8'hBB,8'hAA}.
  - s=0 -> y=8'hAA; s=1 -> 8'hBB; s=2 -> 8'hCC; s=3 -> 8'hDD.
  - Registered copy appears one cycle later with en=1.
- Unknown select: s=2'bx1 with d=4'b1111.
  - Required: y=0 and sel_oh=4'b0000.
